reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning the internal bus address width.
REQ-002 SHALL have parameter DW, default 8, meaning the internal bus data width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have ports m0_req / m1_req, input, 1 each: the master requests bus ownership and holds it high for the whole transaction.
REQ-006 SHALL have ports m0_gnt / m1_gnt, output, 1 each, registered: ownership granted.
REQ-007 SHALL have ports m0_addr / m1_addr, input, AW each: the master address.
REQ-008 SHALL have ports m0_wr_data / m1_wr_data, input, DW each: the master write data.
REQ-009 SHALL have ports m0_write, m0_read, m1_write and m1_read, input, 1 each: single-cycle strobes.
REQ-010 SHALL have ports m0_rd_valid / m1_rd_valid, output, 1 each: read data valid to that master.
REQ-011 SHALL have port rd_data, output, DW: the slave read data broadcast to both masters.
REQ-012 SHALL have ports s_addr, output, AW; s_wr_data, output, DW; s_write, output, 1; s_read, output, 1: the register-file side.
REQ-013 SHALL have port s_rd_data, input, DW: valid exactly one cycle after s_read.

Function
REQ-014 SHALL implement states IDLE, OWN0 and OWN1, with at most one grant high at any time.
REQ-015 In IDLE, a single requester SHALL be granted on the next edge (1-cycle grant latency).
REQ-016 With both requests high in IDLE, the master not served last SHALL win (round-robin via a 1-bit last pointer).
REQ-017 The grant SHALL be held while the owner's req is high; there is no preemption and no timeout.
REQ-018 When the owner drops req and the other req is high, ownership SHALL pass directly to the other master on the next edge, with no IDLE cycle. Otherwise the arbiter SHALL return to IDLE.
REQ-019 s_addr and s_wr_data SHALL combinationally follow the owner's inputs. In IDLE they SHALL be held at zero.
REQ-020 s_write and s_read SHALL combinationally equal the owner's strobe gated by its grant. Strobes from a non-owner SHALL be ignored and SHALL never reach the slave.
REQ-021 If write and read are both high in the same cycle, the write SHALL be forwarded and the read dropped.
REQ-022 A read SHALL set a pending flag. On the next cycle rd_data shall equal s_rd_data and the owner's rd_valid SHALL pulse for 1 cycle, after which the pending flag clears.
REQ-023 If the owner drops req while a read is pending, release SHALL be deferred until rd_valid has been delivered.
REQ-024 rd_data SHALL be registered and SHALL hold its last value between reads.

Reset
REQ-025 Asserting rst SHALL asynchronously force: state IDLE; both gnt 0; both rd_valid 0; pending 0; last pointer = 1 (so m0 wins the first tie); rd_data 0.
REQ-026 Reset mid-transaction SHALL abort it with no s_write/s_read emitted after assertion. Arbitration SHALL resume on the first edge after deassertion.

Structure
REQ-027 State encoding and the reset pointer value SHALL live in the shared package; AW and DW SHALL remain module parameters.
REQ-028 The block SHALL be a single module with no sub-modules. The read-return path SHALL be in the same file.

Verification
REQ-029 Test 1: m0_req only, then write 0x01 to address 0x0000. m0_gnt SHALL rise 1 cycle later, and s_write, s_addr=0x0000 and s_wr_data=0x01 SHALL appear in the same cycle as the strobe.
REQ-030 Test 2: after reset, m0_req and m1_req both rise together. m0 SHALL be granted first; when m0 drops req, m1_gnt SHALL rise on the next edge with no IDLE cycle.
REQ-031 Test 3: m1 owns the bus and reads 0x001A, with the slave returning 0x5A. m1_rd_valid SHALL pulse 1 cycle later with rd_data=0x5A, and m0_rd_valid SHALL stay 0.
REQ-032 Test 4: m1 pulses m1_write with address 0x0010 while m0 owns the bus. There SHALL be no s_write for address 0x0010, and the slave SHALL be unchanged.
REQ-033 Test 5: m0 reads, then drops req in the same cycle, with m1_req high. m1_gnt SHALL rise only after m0_rd_valid has pulsed.
REQ-034 Test 6: rst is asserted while m0 is granted. All outputs SHALL be zero immediately, and after release a pending m1_req SHALL be granted 1 cycle later.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the two-master register-bus arbiter.
package reg_bus_arbiter_pkg;

  // Each grant is a single state bit, so the grants come straight from a flop.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

  // Reset value of the last-served pointer: m1 counts as served last, so m0 wins the first tie.
  localparam logic LastRst = 1'b1;

endpackage

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that lets two masters share one register-file slave,
// including the one-cycle read return path back to the owning master.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  output logic          m0_gnt,
  output logic          m1_gnt,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic [DW-1:0] m1_wr_data,
  input  logic          m0_write,
  input  logic          m0_read,
  input  logic          m1_write,
  input  logic          m1_read,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wr_data,
  output logic          s_write,
  output logic          s_read,
  input  logic [DW-1:0] s_rd_data
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;
  logic [1:0]    rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          own0, own1;
  logic          rd_req;
  logic          busy;

  assign own0        = state_q[0];
  assign own1        = state_q[1];
  assign m0_gnt      = own0;
  assign m1_gnt      = own1;
  assign m0_rd_valid = rd_valid_q[0];
  assign m1_rd_valid = rd_valid_q[1];
  assign rd_data     = rd_data_q;

  // Slave side follows the owner; idle drives zeros and non-owner strobes never pass.
  always_comb begin
    s_addr    = '0;
    s_wr_data = '0;
    s_write   = 1'b0;
    rd_req    = 1'b0;
    case (state_q)
      StOwn0: begin
        s_addr    = m0_addr;
        s_wr_data = m0_wr_data;
        s_write   = m0_write;
        rd_req    = m0_read;
      end
      StOwn1: begin
        s_addr    = m1_addr;
        s_wr_data = m1_wr_data;
        s_write   = m1_write;
        rd_req    = m1_read;
      end
      default: ;
    endcase
    s_read = rd_req & ~s_write;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    pend_d     = s_read;
    rd_valid_d = 2'b00;
    rd_data_d  = rd_data_q;
    // Slave data is valid in the cycle after the strobe; register it for the owner.
    if (pend_q) begin
      rd_valid_d = {own1, own0};
      rd_data_d  = s_rd_data;
    end
    // Hold ownership until an outstanding read has been returned.
    busy = s_read | pend_q;
    case (state_q)
      StIdle: begin
        if (m0_req && (!m1_req || last_q)) begin
          state_d = StOwn0;
          last_d  = 1'b0;
        end else if (m1_req) begin
          state_d = StOwn1;
          last_d  = 1'b1;
        end
      end
      StOwn0: begin
        if (!m0_req && !busy) begin
          if (m1_req) begin
            state_d = StOwn1;
            last_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOwn1: begin
        if (!m1_req && !busy) begin
          if (m0_req) begin
            state_d = StOwn0;
            last_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      last_q     <= LastRst;
      pend_q     <= 1'b0;
      rd_valid_q <= 2'b00;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_reg_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [15:0] m0_addr, m1_addr, s_addr;
  logic [7:0]  m0_wr_data, m1_wr_data, s_wr_data, rd_data, s_rd_data;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic        m0_rd_valid, m1_rd_valid, s_write, s_read;

  reg_bus_arbiter #(.AW(16), .DW(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .m0_gnt     (m0_gnt),
    .m1_gnt     (m1_gnt),
    .m0_addr    (m0_addr),
    .m1_addr    (m1_addr),
    .m0_wr_data (m0_wr_data),
    .m1_wr_data (m1_wr_data),
    .m0_write   (m0_write),
    .m0_read    (m0_read),
    .m1_write   (m1_write),
    .m1_read    (m1_read),
    .m0_rd_valid(m0_rd_valid),
    .m1_rd_valid(m1_rd_valid),
    .rd_data    (rd_data),
    .s_addr     (s_addr),
    .s_wr_data  (s_wr_data),
    .s_write    (s_write),
    .s_read     (s_read),
    .s_rd_data  (s_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    logic [7:0] v;
    v = a[7:0] ^ 8'hA5;
    if (a == 32'h1A) v = 8'h5A;
    return v;
  endfunction

  // Register-file slave: read data appears one cycle after the strobe.
  logic [7:0] smem [0:255];
  initial for (int i = 0; i < 256; i++) smem[i] <= pat(i);
  always @(posedge clk) begin
    if (s_write) smem[s_addr[7:0]] <= s_wr_data;
    if (s_read) s_rd_data <= smem[s_addr[7:0]];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, when reads return, and what the slave holds.
  typedef struct {
    int         cyc;
    int         m;
    logic [7:0] d;
  } dlv_t;

  dlv_t       dq[$];
  logic [7:0] mmem [0:255];
  int         owner;
  logic       last;
  int         rd_cyc;
  int         cyc;
  logic [7:0] rd_hold;

  task automatic model_reset();
    owner   = -1;
    last    = 1'b1;
    rd_cyc  = -10;
    rd_hold = 8'h00;
    dq.delete();
  endtask

  task automatic run_cyc(input logic r0, input logic r1, input logic [15:0] a0,
                         input logic [15:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                         input logic w0, input logic rd0, input logic w1, input logic rd1);
    logic [1:0]  eg, erv;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew, er;
    dlv_t        t;
    m0_req = r0; m1_req = r1; m0_addr = a0; m1_addr = a1;
    m0_wr_data = d0; m1_wr_data = d1;
    m0_write = w0; m0_read = rd0; m1_write = w1; m1_read = rd1;
    @(negedge clk);
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    ea = '0; ed = '0; ew = 1'b0; er = 1'b0;
    if (owner == 0) begin
      ea = a0; ed = d0; ew = w0; er = rd0 && !w0;
    end else if (owner == 1) begin
      ea = a1; ed = d1; ew = w1; er = rd1 && !w1;
    end
    erv = 2'b00;
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      erv     = (dq[0].m == 0) ? 2'b01 : 2'b10;
      rd_hold = dq[0].d;
      void'(dq.pop_front());
    end
    check("gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
    check("rd_valid", 32'({m1_rd_valid, m0_rd_valid}), 32'(erv));
    check("rd_data", 32'(rd_data), 32'(rd_hold));
    check("strobes", 32'({s_write, s_read}), 32'({ew, er}));
    check("s_addr", 32'(s_addr), 32'(ea));
    check("s_wr_data", 32'(s_wr_data), 32'(ed));
    if (er) begin
      t.cyc = cyc + 2; t.m = owner; t.d = mmem[ea[7:0]];
      dq.push_back(t);
      rd_cyc = cyc;
    end
    if (ew) mmem[ea[7:0]] = ed;
    if (owner < 0) begin
      if (r0 && r1) owner = last ? 0 : 1;
      else if (r0) owner = 0;
      else if (r1) owner = 1;
      if (owner >= 0) last = (owner == 1);
    end else if (!((owner == 0) ? r0 : r1) && (cyc - rd_cyc) > 1) begin
      if ((owner == 0) ? r1 : r0) begin
        owner = 1 - owner;
        last  = (owner == 1);
      end else begin
        owner = -1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Reset lands mid-cycle with live strobes; every output must clear at once.
  task automatic do_reset();
    m0_write = 1'b1; m1_read = 1'b1; m0_addr = 16'h1234; m0_wr_data = 8'h77;
    rst = 1'b0;
    #1;
    check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    check("rst_rd_valid", 32'({m1_rd_valid, m0_rd_valid}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_strobes", 32'({s_write, s_read}), 32'd0);
    check("rst_s_addr", 32'(s_addr), 32'd0);
    check("rst_s_wr_data", 32'(s_wr_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  logic rr0, rr1;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = pat(i);
    cyc = 0;
    model_reset();
    rst = 1'b0;
    m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_wr_data = 0; m1_wr_data = 0;
    m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single requester, then a write to address 0.
    run_cyc(1, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0);
    run_cyc(1, 0, 16'h0000, 0, 8'h01, 0, 1, 0, 0, 0);
    check("t1_mem", 32'(smem[0]), 32'h01);

    // Tie after reset goes to m0, then hands straight to m1.
    do_reset();
    run_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // m1 reads 0x001A.
    run_cyc(0, 1, 0, 16'h001A, 0, 0, 0, 0, 0, 1);
    run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_rd_data", 32'(rd_data), 32'h5A);

    // m1 writes while m0 owns: must not reach the slave.
    run_cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(1, 1, 16'h0000, 16'h0010, 8'h00, 8'hEE, 0, 0, 1, 0);
    run_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_mem", 32'(smem[16]), 32'(pat(16)));

    // m0 reads and drops req in the same cycle; handoff waits for rd_valid.
    run_cyc(0, 1, 16'h0003, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while m0 owns, with m1 waiting.
    run_cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    rr0 = 1'b0;
    rr1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rr0 = ~rr0;
      if ($urandom_range(0, 7) == 0) rr1 = ~rr1;
      if ($urandom_range(0, 399) == 0) do_reset();
      run_cyc(rr0, rr1, 16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)),
              8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
